// File: rtl/ascon_inv_permutation.sv
// ascon_inv_permutation: iterative inverse Ascon p^n (n = 12/8/6) with valid/ready handshakes.
// Define ASCON_INV_UNROLL2_EN to apply two inverse rounds per clock instead of one.
module ascon_inv_permutation (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  rounds_i,
    input  logic [63:0] x0_i,
    input  logic [63:0] x1_i,
    input  logic [63:0] x2_i,
    input  logic [63:0] x3_i,
    input  logic [63:0] x4_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [63:0] x0_o,
    output logic [63:0] x1_o,
    output logic [63:0] x2_o,
    output logic [63:0] x3_o,
    output logic [63:0] x4_o
);
    typedef logic [4:0][63:0] state_w_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
`ifdef ASCON_INV_UNROLL2_EN
    localparam logic [3:0] STEP = 4'd2;
`else
    localparam logic [3:0] STEP = 4'd1;
`endif
    localparam logic [0:31][4:0] INV_SBOX = {
        5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
        5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
        5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
        5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
    };

    fsm_t        state, state_nxt;
    state_w_t    st, st_nxt;
    logic [3:0]  k, k_last;
    logic        last;

    function automatic logic [63:0] ror(input logic [63:0] v, input int s);
        return (v >> s) | (v << (64 - s));
    endfunction

    // L = 1 + R^a + R^b satisfies L^64 = 1 over GF(2), so L^-1 = L^63 = L^1 L^2 L^4 ... L^32,
    // and L^(2^i) is again a three-term rotation XOR with amounts scaled by 2^i.
    function automatic logic [63:0] inv_lin(input logic [63:0] v, input int a, input int b);
        logic [63:0] y;
        y = v;
        for (int i = 0; i < 6; i++) y = y ^ ror(y, (a << i) % 64) ^ ror(y, (b << i) % 64);
        return y;
    endfunction

    function automatic state_w_t inv_round(input state_w_t x, input logic [3:0] kk);
        state_w_t y, z;
        y[0] = inv_lin(x[0], 19, 28);
        y[1] = inv_lin(x[1], 61, 39);
        y[2] = inv_lin(x[2], 1, 6);
        y[3] = inv_lin(x[3], 10, 17);
        y[4] = inv_lin(x[4], 7, 41);
        for (int j = 0; j < 64; j++)
            {z[0][j], z[1][j], z[2][j], z[3][j], z[4][j]} =
                INV_SBOX[{y[0][j], y[1][j], y[2][j], y[3][j], y[4][j]}];
        z[2][7:0] = z[2][7:0] ^ (8'h4b + {4'd0, kk} * 8'h0f);
        return z;
    endfunction

    // round datapath from the state register and FSM next-state
    always_comb begin
        st_nxt = inv_round(st, k);
`ifdef ASCON_INV_UNROLL2_EN
        st_nxt = inv_round(st_nxt, k + 4'd1);
`endif
        last = (k + STEP - 4'd1) == k_last;
        state_nxt = state == IDLE ? (valid_i ? RUN : IDLE) :
                    state == RUN  ? (last ? DONE : RUN) :
                                    (ready_i ? IDLE : DONE);
    end

    // state register, round counter and job parameters latched on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            st     <= '0;
            k      <= '0;
            k_last <= 4'd11;
        end else begin
            state <= state_nxt;
            if (state == IDLE && valid_i) begin
                st     <= {x4_i, x3_i, x2_i, x1_i, x0_i};
                k      <= '0;
                k_last <= rounds_i == 2'b01 ? 4'd7 : rounds_i == 2'b10 ? 4'd5 : 4'd11;
            end else if (state == RUN) begin
                st <= st_nxt;
                k  <= k + STEP;
            end
        end
    end

    assign ready_o = state == IDLE;
    assign valid_o = state == DONE;
    assign x0_o    = st[0];
    assign x1_o    = st[1];
    assign x2_o    = st[2];
    assign x3_o    = st[3];
    assign x4_o    = st[4];
endmodule
